sppf_pool_scheduler: RTL and testbench

// Sequences one shared 5x5 stride-1 max-pool engine through the three cascaded SPPF passes:
// P1=pool(X), P2=pool(P1), P3=pool(P2), same-size output with 2-row/2-col -inf padding.

---
 rtl/sppf_pool_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sppf_pool_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sppf_pool_scheduler.sv
// SPPF pool scheduler: walks one shared 5x5 stride-1 max-pool engine through
// the three cascaded passes P1=pool(X), P2=pool(P1), P3=pool(P2). Each job is a
// single output row of one channel: request the 5-row tile, wait for it, pulse
// the engine, wait ENG_LAT cycles, then hand the result row to writeback.
module sppf_pool_scheduler #(
  parameter int H       = 20,
  parameter int C       = 512,
  parameter int ENG_LAT = 2,
  localparam int ROW_W  = (H > 1) ? $clog2(H) : 1,
  localparam int CH_W   = (C > 1) ? $clog2(C) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [1:0]       req_pass,
  output logic [CH_W-1:0]  req_ch,
  output logic [ROW_W-1:0] req_row,
  output logic [4:0]       pad_mask,
  input  logic             tile_valid,
  output logic             eng_load,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [1:0]       wb_dst
);

  localparam int CNT_W = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(H - 1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(C - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ENG_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_TILE,
    S_POOL,
    S_WB,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;

  logic [ROW_W-1:0] row_n;
  logic [CH_W-1:0]  ch_n;
  logic [1:0]       pass_n;
  logic             last_job;

  // Window row r-2+i is padding when it falls above row 0 or below row H-1.
  function automatic logic [4:0] pad_of(input logic [ROW_W-1:0] r);
    int         rv;
    logic [4:0] m;
    rv = int'(r);
    for (int i = 0; i < 5; i++) begin
      m[i] = ((rv + i) < 2) || ((rv + i) > (H + 1));
    end
    return m;
  endfunction

  // Next job coordinates: row innermost, then channel, then pass.
  always_comb begin
    row_n    = req_row;
    ch_n     = req_ch;
    pass_n   = req_pass;
    last_job = (req_pass == 2'd2) && (req_ch == CH_MAX) && (req_row == ROW_MAX);
    if (req_row == ROW_MAX) begin
      row_n = '0;
      if (req_ch == CH_MAX) begin
        ch_n   = '0;
        pass_n = last_job ? 2'd0 : req_pass + 2'd1;
      end else begin
        ch_n = req_ch + 1'b1;
      end
    end else begin
      row_n = req_row + 1'b1;
    end
  end

  // Job sequencer: all outputs are registered here so they hold for a whole job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_valid <= 1'b0;
      eng_load  <= 1'b0;
      wb_valid  <= 1'b0;
      req_pass  <= '0;
      req_ch    <= '0;
      req_row   <= '0;
      pad_mask  <= '0;
      wb_dst    <= '0;
      lat_cnt   <= '0;
    end else begin
      eng_load <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          pad_mask <= pad_of(req_row);
          wb_dst   <= req_pass + 2'd1;
          if (start) begin
            state     <= S_REQ;
            busy      <= 1'b1;
            req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_WAIT_TILE;
          end
        end
        S_WAIT_TILE: begin
          if (tile_valid) begin
            eng_load <= 1'b1;
            lat_cnt  <= '0;
            state    <= S_POOL;
          end
        end
        S_POOL: begin
          if (lat_cnt == CNT_MAX) begin
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          req_row  <= row_n;
          req_ch   <= ch_n;
          req_pass <= pass_n;
          pad_mask <= pad_of(row_n);
          wb_dst   <= pass_n + 2'd1;
          if (last_job) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            req_valid <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sppf_pool_scheduler.sv
// Bench for sppf_pool_scheduler: job list predicted from the pass/channel/row
// loop order, checked by a monitor against the DUT handshakes.
module tb_sppf_pool_scheduler;

  localparam int H   = 6;
  localparam int C   = 2;
  localparam int LAT = 2;
  localparam int NJOB = 3 * C * H;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic req_ready  = 1'b0;
  logic tile_valid = 1'b0;
  logic wb_ready   = 1'b0;
  logic busy, done, req_valid, eng_load, wb_valid;
  logic [1:0] req_pass, wb_dst;
  logic [0:0] req_ch;
  logic [2:0] req_row;
  logic [4:0] pad_mask;

  // single-row, single-channel instance
  logic s_start = 1'b0;
  logic s_req_ready  = 1'b1;
  logic s_tile_valid = 1'b1;
  logic s_wb_ready   = 1'b1;
  logic s_busy, s_done, s_req_valid, s_eng_load, s_wb_valid;
  logic [1:0] s_req_pass, s_wb_dst;
  logic [0:0] s_req_ch;
  logic [0:0] s_req_row;
  logic [4:0] s_pad_mask;

  sppf_pool_scheduler #(.H(H), .C(C), .ENG_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_pass(req_pass),
    .req_ch(req_ch), .req_row(req_row), .pad_mask(pad_mask),
    .tile_valid(tile_valid), .eng_load(eng_load), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_dst(wb_dst)
  );

  sppf_pool_scheduler #(.H(1), .C(1), .ENG_LAT(LAT)) u_dut1 (
    .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_pass(s_req_pass),
    .req_ch(s_req_ch), .req_row(s_req_row), .pad_mask(s_pad_mask),
    .tile_valid(s_tile_valid), .eng_load(s_eng_load), .wb_valid(s_wb_valid),
    .wb_ready(s_wb_ready), .wb_dst(s_wb_dst)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int c; int r; } job_t;
  job_t reqq[$];
  job_t wbq[$];
  job_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_hs, wb_hs, done_cnt, load_cnt, load_cyc, last_wb, done_cyc;
  int s_idx, s_widx, s_done_cnt, s_load_cnt, s_last;
  int mode = 0;
  bit hold_req = 0;
  bit hold_wb = 0;
  logic        pv_req, pv_rdy, pv_wb, pv_wbr, prev_done;
  logic [11:0] pv_fields;
  logic [1:0]  pv_dst;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [4:0] pad_ref(input int r, input int h);
    logic [4:0] m;
    for (int i = 0; i < 5; i++) m[i] = ((r - 2 + i) < 0) || ((r - 2 + i) >= h);
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Peer models: fetch unit, tile loader and writeback unit.
  always @(posedge clk) begin
    #1;
    if (mode == 0) begin
      req_ready  = 1'b1;
      tile_valid = 1'b1;
      wb_ready   = 1'b1;
    end else begin
      req_ready  = ($urandom_range(0, 1) == 1);
      tile_valid = ($urandom_range(0, 2) == 0);
      wb_ready   = ($urandom_range(0, 1) == 1);
    end
    if (hold_req) req_ready = 1'b0;
    if (hold_wb)  wb_ready  = 1'b0;
  end

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (!reset) begin
      pv_req = 0; pv_rdy = 0; pv_wb = 0; pv_wbr = 0; prev_done = 0;
    end else begin
      if (pv_req && !pv_rdy)
        chk("req_hold", int'({req_valid, req_pass, req_ch, req_row, pad_mask}), int'(pv_fields));
      if (pv_wb && !pv_wbr)
        chk("wb_hold", int'({wb_valid, wb_dst}), int'({1'b1, pv_dst}));
      if (prev_done) begin
        chk("done_pulse", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
      end
      if (req_valid && req_ready) begin
        req_hs++;
        if (reqq.size() == 0) note_fail("req_unexpected");
        else begin
          mon_e = reqq.pop_front();
          chk("req_pass", int'(req_pass), mon_e.p);
          chk("req_ch", int'(req_ch), mon_e.c);
          chk("req_row", int'(req_row), mon_e.r);
          chk("pad_mask", int'(pad_mask), int'(pad_ref(mon_e.r, H)));
          wbq.push_back(mon_e);
        end
      end
      if (eng_load) begin
        load_cnt++;
        load_cyc = cyc;
      end
      if (wb_valid && !pv_wb) chk("eng_lat", cyc - load_cyc, LAT);
      if (wb_valid && wb_ready) begin
        wb_hs++;
        last_wb = cyc;
        if (wbq.size() == 0) note_fail("wb_unexpected");
        else begin
          mon_e = wbq.pop_front();
          chk("wb_dst", int'(wb_dst), mon_e.p + 1);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_delay", cyc - last_wb, 2);
        chk("done_busy", int'(busy), 1);
      end
      pv_req = req_valid; pv_rdy = req_ready; pv_wb = wb_valid; pv_wbr = wb_ready;
      pv_fields = {req_valid, req_pass, req_ch, req_row, pad_mask};
      pv_dst = wb_dst;
      prev_done = done;
    end
  end

  // Monitor for the H=1, C=1 instance.
  always @(negedge clk) begin
    if (reset) begin
      if (s_req_valid && s_req_ready) begin
        chk("s_req_pass", int'(s_req_pass), s_idx);
        chk("s_req_row", int'({s_req_ch, s_req_row}), 0);
        chk("s_pad_mask", int'(s_pad_mask), int'(pad_ref(0, 1)));
        s_idx++;
      end
      if (s_eng_load) s_load_cnt++;
      if (s_wb_valid && s_wb_ready) begin
        chk("s_wb_dst", int'(s_wb_dst), s_widx + 1);
        s_widx++;
        s_last = cyc;
      end
      if (s_done) begin
        s_done_cnt++;
        chk("s_done_delay", cyc - s_last, 2);
        chk("s_done_busy", int'(s_busy), 1);
      end
    end
  end

  task automatic load_expect();
    job_t j;
    reqq.delete();
    wbq.delete();
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < C; c++)
        for (int r = 0; r < H; r++) begin
          j.p = p; j.c = c; j.r = r;
          reqq.push_back(j);
        end
    req_hs = 0; wb_hs = 0; done_cnt = 0; load_cnt = 0;
  endtask

  task automatic run_start(output int start_cyc);
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_rise", int'(busy), 1);
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int t;
    t = 0;
    while (done_cnt == 0 && t < maxc) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == 0) note_fail(nm);
    repeat (3) @(posedge clk);
  endtask

  task automatic end_checks(input string nm);
    chk({nm, "_req_hs"}, req_hs, NJOB);
    chk({nm, "_wb_hs"}, wb_hs, NJOB);
    chk({nm, "_loads"}, load_cnt, NJOB);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_left"}, reqq.size() + wbq.size(), 0);
  endtask

  task automatic wait_sig(input int which, input int maxc, input string nm);
    int t;
    bit hit;
    t = 0;
    hit = 0;
    while (!hit && t < maxc) begin
      @(negedge clk);
      t++;
      case (which)
        0: hit = req_valid;
        1: hit = wb_valid;
        2: hit = (req_hs >= 10);
        default: hit = (req_pass == 2'd1) && wb_valid;
      endcase
    end
    if (!hit) note_fail(nm);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    int sc;
    #3 reset = 1'b0;
    #10;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_req_valid", int'(req_valid), 0);
    chk("rst_eng_load", int'(eng_load), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_counters", int'({req_pass, req_ch, req_row}), 0);
    release_reset();

    // full run, zero-wait peers
    mode = 0;
    load_expect();
    run_start(sc);
    wait_done(2000, "run1_timeout");
    end_checks("run1");
    chk("run1_cycles", done_cyc - sc, NJOB * (4 + LAT));

    // random peers, forced backpressure, ignored start mid-run
    mode = 1;
    load_expect();
    run_start(sc);
    hold_req = 1;
    repeat (2) @(posedge clk);
    wait_sig(0, 200, "bp_req_timeout");
    repeat (10) begin
      @(negedge clk);
      chk("bp_req_valid", int'(req_valid), 1);
    end
    hold_req = 0;
    hold_wb = 1;
    repeat (2) @(posedge clk);
    wait_sig(1, 200, "bp_wb_timeout");
    repeat (7) begin
      @(negedge clk);
      chk("bp_wb_valid", int'(wb_valid), 1);
    end
    hold_wb = 0;
    wait_sig(2, 2000, "job10_timeout");
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(8000, "run2_timeout");
    end_checks("run2");

    // abort during a pass-1 writeback, then restart
    load_expect();
    run_start(sc);
    wait_sig(3, 8000, "abort_point_timeout");
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_req_valid", int'(req_valid), 0);
    chk("abort_wb_valid", int'(wb_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_eng_load", int'(eng_load), 0);
    chk("abort_outs", int'({req_pass, req_ch, req_row, pad_mask, wb_dst}), 0);
    chk("abort_no_done", done_cnt, 0);
    release_reset();
    mode = 0;
    load_expect();
    run_start(sc);
    wait_done(2000, "run3_timeout");
    end_checks("run3");

    // H=1, C=1 instance
    s_idx = 0; s_widx = 0; s_done_cnt = 0; s_load_cnt = 0;
    @(posedge clk);
    #1 s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    begin
      int t;
      t = 0;
      while (s_done_cnt == 0 && t < 200) begin
        @(posedge clk);
        t++;
      end
      if (s_done_cnt == 0) note_fail("s_timeout");
    end
    repeat (3) @(posedge clk);
    chk("s_req_hs", s_idx, 3);
    chk("s_wb_hs", s_widx, 3);
    chk("s_loads", s_load_cnt, 3);
    chk("s_done_cnt", s_done_cnt, 1);
    #1 chk("s_idle_busy", int'(s_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
